// File: rtl/sha2_round_engine.sv
// sha2_round_engine: iterative SHA-256/SHA-512 compression of one 16-word block,
// UNROLL rounds per clock, with an on-the-fly message-schedule window.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start / ready   accept a block while idle
//   blk_in          W0..W15 (W0 in MSBs), sampled on acceptance
//   h_in            H0..H7 (H0 in MSBs), sampled on acceptance
//   k_idx / k_in    first round index of this cycle / its UNROLL constants (lowest in MSBs)
//   h_out / done    result chaining state, held until the next done pulse
module sha2_round_engine #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned UNROLL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       ready,
  input  logic [16*WORD_W-1:0]       blk_in,
  input  logic [8*WORD_W-1:0]        h_in,
  output logic [6:0]                 k_idx,
  input  logic [UNROLL*WORD_W-1:0]   k_in,
  output logic [8*WORD_W-1:0]        h_out,
  output logic                       done
);

  localparam int unsigned NR    = (WORD_W == 64) ? 80 : 64;
  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(NR - UNROLL);
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(UNROLL);

  // Rotation / shift amounts for the selected word width
  localparam int unsigned BS0_A = (WORD_W == 64) ? 28 : 2;
  localparam int unsigned BS0_B = (WORD_W == 64) ? 34 : 13;
  localparam int unsigned BS0_C = (WORD_W == 64) ? 39 : 22;
  localparam int unsigned BS1_A = (WORD_W == 64) ? 14 : 6;
  localparam int unsigned BS1_B = (WORD_W == 64) ? 18 : 11;
  localparam int unsigned BS1_C = (WORD_W == 64) ? 41 : 25;
  localparam int unsigned SS0_A = (WORD_W == 64) ? 1  : 7;
  localparam int unsigned SS0_B = (WORD_W == 64) ? 8  : 18;
  localparam int unsigned SS0_S = (WORD_W == 64) ? 7  : 3;
  localparam int unsigned SS1_A = (WORD_W == 64) ? 19 : 17;
  localparam int unsigned SS1_B = (WORD_W == 64) ? 61 : 19;
  localparam int unsigned SS1_S = (WORD_W == 64) ? 6  : 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;

  typedef logic [WORD_W-1:0] word_t;

  // Working vars packed as [7]=a .. [0]=h; window packed as [15]=W[t] .. [0]=W[t+15]
  logic [1:0]              state_q, state_d;
  logic [7:0][WORD_W-1:0]  work_q, work_d;
  logic [7:0][WORD_W-1:0]  saved_q, saved_d;
  logic [15:0][WORD_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0][WORD_W-1:0]  h_out_q, h_out_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;
  logic [7:0][WORD_W-1:0]  rnd_work;
  logic [15:0][WORD_W-1:0] rnd_win;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, BS0_A) ^ rotr(x, BS0_B) ^ rotr(x, BS0_C);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, BS1_A) ^ rotr(x, BS1_B) ^ rotr(x, BS1_C);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, SS0_A) ^ rotr(x, SS0_B) ^ (x >> SS0_S);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, SS1_A) ^ rotr(x, SS1_B) ^ (x >> SS1_S);
  endfunction

  // UNROLL chained rounds plus schedule-window advance from the current registers
  always_comb begin : round_p
    word_t t1, t2, kw;
    rnd_work = work_q;
    rnd_win  = win_q;
    t1 = '0;
    t2 = '0;
    kw = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      kw = k_in[(UNROLL-1-u)*WORD_W +: WORD_W];
      t1 = rnd_work[0] + bsig1(rnd_work[3])
         + ((rnd_work[3] & rnd_work[2]) ^ (~rnd_work[3] & rnd_work[1]))
         + kw + rnd_win[15];
      t2 = bsig0(rnd_work[7])
         + ((rnd_work[7] & rnd_work[6]) ^ (rnd_work[7] & rnd_work[5]) ^ (rnd_work[6] & rnd_work[5]));
      rnd_work = {t1 + t2, rnd_work[7:5], rnd_work[4] + t1, rnd_work[3:1]};
      rnd_win  = {rnd_win[14:0],
                  ssig1(rnd_win[1]) + rnd_win[6] + ssig0(rnd_win[14]) + rnd_win[15]};
    end
  end

  // Next-state and output logic
  always_comb begin : next_p
    state_d = state_q;
    work_d  = work_q;
    saved_d = saved_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    h_out_d = h_out_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          work_d  = h_in;
          saved_d = h_in;
          win_d   = blk_in;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d = rnd_work;
        win_d  = rnd_win;
        if (cnt_q == LAST_T) begin
          cnt_d   = '0;
          state_d = S_ADD;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      S_ADD: begin
        for (int i = 0; i < 8; i++) h_out_d[i] = saved_q[i] + work_q[i];
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      saved_q <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      h_out_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      saved_q <= saved_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      h_out_q <= h_out_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign k_idx = cnt_q;
  assign h_out = h_out_q;
  assign done  = done_q;

endmodule
